// File: rtl/sum_splitter.sv
// sum_splitter: splits one signed sum word into a stream of (a, b) operand
// pairs whose running total equals the word; valid/ready on both sides.
// Ports:
//   clk, rst (async, active high)
//   in_valid / in_ready / in_data[IN_WIDTH]            : sum word input
//   out_valid / out_ready / out_a, out_b[OP_WIDTH]     : operand pair output
//   out_last (final beat of word), out_beat[BEAT_WIDTH] (0-based beat index)
module sum_splitter #(
    parameter int IN_WIDTH   = 5,
    parameter int OP_WIDTH   = 2,
    parameter int BEAT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_WIDTH-1:0]   out_a,
    output logic [OP_WIDTH-1:0]   out_b,
    output logic                  out_last,
    output logic [BEAT_WIDTH-1:0] out_beat
);

    // One extra bit keeps r - a in range even for the most negative input.
    localparam int RW = IN_WIDTH + 1;

    localparam logic signed [RW-1:0] OPMAX = RW'((1 << (OP_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] OPMIN = RW'(-(1 << (OP_WIDTH - 1)));

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t state, state_nxt;

    logic signed [RW-1:0]   r;
    logic [BEAT_WIDTH-1:0]  beat;

    logic signed [OP_WIDTH-1:0] a_op, b_op;
    logic signed [RW-1:0]       a_ext, b_ext, r_sub_a, rn;
    logic                       last;

    function automatic logic signed [OP_WIDTH-1:0] clamp(
        input logic signed [RW-1:0] v
    );
        if (v > OPMAX) begin
            return OPMAX[OP_WIDTH-1:0];
        end else if (v < OPMIN) begin
            return OPMIN[OP_WIDTH-1:0];
        end
        return v[OP_WIDTH-1:0];
    endfunction

    // Greedy split: take as much of the remainder as each operand can hold.
    always_comb begin
        a_op    = clamp(r);
        a_ext   = {{(RW - OP_WIDTH){a_op[OP_WIDTH-1]}}, a_op};
        r_sub_a = r - a_ext;
        b_op    = clamp(r_sub_a);
        b_ext   = {{(RW - OP_WIDTH){b_op[OP_WIDTH-1]}}, b_op};
        rn      = r_sub_a - b_ext;
        last    = (rn == '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = EMIT;
            EMIT: if (out_ready && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Remainder and beat index only move on an accepted word or a
    // transferred non-final beat, so a stalled beat stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r    <= '0;
            beat <= '0;
        end else if (state == IDLE && in_valid) begin
            r    <= {in_data[IN_WIDTH-1], in_data};
            beat <= '0;
        end else if (state == EMIT && out_ready && !last) begin
            r    <= rn;
            beat <= beat + 1'b1;
        end
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_a     = '0;
        out_b     = '0;
        out_last  = 1'b0;
        out_beat  = beat;
        unique case (state)
            IDLE: begin
                // Not ready while reset is held.
                in_ready = !rst;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_a     = a_op;
                out_b     = b_op;
                out_last  = last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_splitter.sv
// tb_sum_splitter: scoreboard bench for sum_splitter.
// Expected beats are queued at word acceptance and compared on transfer.
module tb_sum_splitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_a, out_b;
    logic       out_last;
    logic [3:0] out_beat;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] q[$];
    int         wq[$];
    int         acc = 0;
    int         beats = 0;
    bit         toggle = 1'b0;
    bit         stalled_prev = 1'b0;
    logic [9:0] held;

    sum_splitter dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_last (out_last),
        .out_beat (out_beat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    function automatic int clampi(int v);
        if (v > 1) return 1;
        if (v < -2) return -2;
        return v;
    endfunction

    function automatic void push_model(int v);
        int r, a, b, bt;
        logic lst;
        r  = v;
        bt = 0;
        do begin
            a   = clampi(r);
            b   = clampi(r - a);
            r   = r - a - b;
            lst = (r == 0);
            q.push_back({a[1:0], b[1:0], lst, bt[3:0]});
            bt++;
        end while (r != 0);
        wq.push_back(v);
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = toggle ? ~out_ready : 1'b1;
    end

    // Monitor: compare transfers, hold-stability and per-word sums.
    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                chk("hold", {22'd0, out_valid, out_a, out_b, out_last, out_beat},
                    {22'd0, held});
            end
            if (out_valid && out_ready) begin
                beats++;
                acc = acc + int'($signed(out_a)) + int'($signed(out_b));
                if (q.size() == 0) begin
                    chk("extra_beat", 32'd1, 32'd0);
                end else begin
                    chk("beat", {23'd0, out_a, out_b, out_last, out_beat},
                        {23'd0, q.pop_front()});
                end
                if (out_last) begin
                    if (wq.size() != 0) chk("sum", acc, wq.pop_front());
                    acc = 0;
                end
            end
            stalled_prev = out_valid && !out_ready;
            held = {out_valid, out_a, out_b, out_last, out_beat};
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Sends one word, checks first-beat latency, returns busy cycles.
    task automatic send_word(input int v, output int low);
        int n;
        wait_ready();
        beats    = 0;
        in_valid = 1'b1;
        in_data  = v[4:0];
        @(posedge clk);
        push_model(v);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("latency", {31'd0, out_valid}, 32'd1);
        n = 0;
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        low = n;
        if (!in_ready) chk("drain_timeout", 32'd0, 32'd1);
        chk("drained", q.size(), 32'd0);
    endtask

    initial begin
        int low;
        int v;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_outs", {23'd0, out_valid, out_a, out_b, out_last, out_beat},
            32'd0);

        send_word(7, low);
        chk("busy7", low, 32'd4);
        chk("beats7", beats, 32'd4);
        send_word(-5, low);
        chk("beats-5", beats, 32'd2);
        send_word(0, low);
        chk("beats0", beats, 32'd1);
        send_word(-16, low);
        chk("beats-16", beats, 32'd4);
        send_word(15, low);
        chk("beats15", beats, 32'd8);

        toggle = 1'b1;
        send_word(3, low);
        chk("beats3_stall", beats, 32'd2);
        send_word(-9, low);
        toggle = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 31)) - 16;
            send_word(v, low);
        end

        // Reset in the middle of a word.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 5'd7;
        @(posedge clk);
        push_model(7);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_beat == 4'd1) break;
        end
        chk("mid_beat", {28'd0, out_beat}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        wq.delete();
        acc = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_outs", {23'd0, out_valid, out_a, out_b, out_last, out_beat},
            32'd0);
        send_word(-5, low);
        chk("post_rst_beats", beats, 32'd2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
